// File: rtl/cnn_inst_sequencer_if.sv
// Instruction-path bundle between the sequencer, the instruction ROM and the parser.
// master = sequencer side; slave = ROM/parser side.
interface cnn_inst_sequencer_if #(
  parameter int INST_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
) ();
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [INST_WIDTH-1:0] inst_q;
  logic [INST_WIDTH-1:0] parser_inst;
  logic                  parser_en;
  logic                  parser_ready;

  modport master (
    output inst_addr, parser_inst, parser_en,
    input  inst_q, parser_ready
  );

  modport slave (
    input  inst_addr, parser_inst, parser_en,
    output inst_q, parser_ready
  );
endinterface

// File: rtl/cnn_inst_sequencer.sv
// CNN instruction sequencer: fetches from ROM, issues compute instructions to the
// parser, runs one hardware loop level, and guards runs with watchdog/abort/pc overflow.
//
// state  | meaning
// IDLE   | waiting for start, ready=1
// FETCH  | inst_addr=pc, waiting out ROM latency
// DECODE | NOP ends run, LOOP redirects pc, compute waits for parser_ready
// ISSUE  | parser_en pulse scheduled, watchdog cleared
// SETTLE | ignore parser_ready for SETTLE_CYCLES
// WAIT   | wait for parser_ready, then advance pc
module cnn_inst_sequencer #(
  parameter int         DATA_WIDTH    = 32,
  parameter int         INST_WIDTH    = 128,
  parameter int         ADDR_WIDTH    = 16,
  parameter int         ROM_LATENCY   = 2,
  parameter int         SETTLE_CYCLES = 5,
  parameter logic [7:0] LOOP_OPCODE   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] timeout_limit,
  cnn_inst_sequencer_if.master  bus,
  output logic                  ready,
  output logic                  done,
  output logic [1:0]            status,
  output logic [DATA_WIDTH-1:0] cycle_cnt,
  output logic [DATA_WIDTH-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_SETTLE, S_WAIT
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ABORT   = 2'd2;
  localparam logic [1:0] ST_OVF     = 2'd3;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_d;
  logic                  loop_active, loop_active_d;
  logic [15:0]           loop_cnt, loop_cnt_d;
  logic [7:0]            tmr;
  logic [DATA_WIDTH-1:0] wd_cnt, wd_inc;
  logic                  wd_expire;
  logic                  end_run, inst_done;
  logic [1:0]            end_code;
  logic [INST_WIDTH-1:0] parser_inst;
  logic                  parser_en;

  logic [7:0]            opcode;
  logic                  is_nop, pc_max;
  logic [ADDR_WIDTH-1:0] loop_tgt;
  logic [15:0]           loop_n;

  assign opcode   = bus.inst_q[INST_WIDTH-1 -: 8];
  assign is_nop   = (bus.inst_q == '0);
  assign loop_tgt = bus.inst_q[ADDR_WIDTH-1:0];
  assign loop_n   = bus.inst_q[ADDR_WIDTH+15:ADDR_WIDTH];
  assign pc_max   = &pc;

  // Watchdog fires on the edge at which the count would reach the limit.
  assign wd_inc    = wd_cnt + DATA_WIDTH'(1);
  assign wd_expire = (timeout_limit != '0) && (wd_inc >= timeout_limit);

  assign ready           = (state == S_IDLE);
  assign bus.inst_addr   = pc;
  assign bus.parser_inst = parser_inst;
  assign bus.parser_en   = parser_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    pc_d          = pc;
    loop_active_d = loop_active;
    loop_cnt_d    = loop_cnt;
    end_run       = 1'b0;
    end_code      = ST_OK;
    inst_done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !done) begin
          state_next    = S_FETCH;
          pc_d          = start_addr;
          loop_active_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (tmr == '0) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_nop) begin
          end_run = 1'b1;
        end else if (opcode == LOOP_OPCODE) begin
          if (loop_active && loop_cnt != '0) begin
            loop_cnt_d = loop_cnt - 16'd1;
            pc_d       = loop_tgt;
            state_next = S_FETCH;
          end else if (!loop_active && loop_n != '0) begin
            loop_active_d = 1'b1;
            loop_cnt_d    = loop_n - 16'd1;
            pc_d          = loop_tgt;
            state_next    = S_FETCH;
          end else if (pc_max) begin
            end_run  = 1'b1;
            end_code = ST_OVF;
          end else begin
            loop_active_d = 1'b0;
            pc_d          = pc + ADDR_WIDTH'(1);
            state_next    = S_FETCH;
          end
        end else if (bus.parser_ready) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_SETTLE;
      S_SETTLE: begin
        if (wd_expire) begin
          end_run  = 1'b1;
          end_code = ST_TIMEOUT;
        end else if (tmr == '0) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wd_expire) begin
          end_run  = 1'b1;
          end_code = ST_TIMEOUT;
        end else if (bus.parser_ready) begin
          inst_done = 1'b1;
          if (pc_max) begin
            end_run  = 1'b1;
            end_code = ST_OVF;
          end else begin
            pc_d       = pc + ADDR_WIDTH'(1);
            state_next = S_FETCH;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Abort overrides whatever the state wanted to do this cycle.
    if (state != S_IDLE && abort) begin
      end_run       = 1'b1;
      end_code      = ST_ABORT;
      inst_done     = 1'b0;
      pc_d          = pc;
      loop_active_d = loop_active;
      loop_cnt_d    = loop_cnt;
    end
    if (end_run) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      loop_active <= 1'b0;
      loop_cnt    <= '0;
      tmr         <= '0;
      wd_cnt      <= '0;
      parser_inst <= '0;
      parser_en   <= 1'b0;
      done        <= 1'b0;
      status      <= ST_OK;
      cycle_cnt   <= '0;
      inst_cnt    <= '0;
    end else begin
      pc          <= pc_d;
      loop_active <= loop_active_d;
      loop_cnt    <= loop_cnt_d;
      done        <= end_run;
      parser_en   <= (state == S_ISSUE) && !end_run;

      if (state == S_DECODE && state_next == S_ISSUE) parser_inst <= bus.inst_q;

      if (state_next == S_FETCH && state != S_FETCH)
        tmr <= 8'(ROM_LATENCY);
      else if (state_next == S_SETTLE && state != S_SETTLE)
        tmr <= 8'(SETTLE_CYCLES - 1);
      else if (tmr != '0)
        tmr <= tmr - 8'd1;

      if (state == S_ISSUE) wd_cnt <= '0;
      else if (state == S_SETTLE || state == S_WAIT) wd_cnt <= wd_inc;

      if (state == S_IDLE && state_next == S_FETCH) begin
        cycle_cnt <= '0;
        inst_cnt  <= '0;
        status    <= ST_OK;
      end else begin
        if (state != S_IDLE && !(&cycle_cnt)) cycle_cnt <= cycle_cnt + DATA_WIDTH'(1);
        if (inst_done) inst_cnt <= inst_cnt + DATA_WIDTH'(1);
        if (end_run) status <= end_code;
      end
    end
  end

endmodule

// File: tb/tb_cnn_inst_sequencer.sv
// Directed bench for cnn_inst_sequencer: linear, loop, timeout, abort, overflow, async reset.
module tb_cnn_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic        abort = 1'b0;
  logic [31:0] timeout_limit = '0;
  logic        ready, done;
  logic [1:0]  status;
  logic [31:0] cycle_cnt, inst_cnt;

  logic        start4 = 1'b0;
  logic [3:0]  start_addr4 = '0;
  logic        ready4, done4;
  logic [1:0]  status4;
  logic [31:0] cycle_cnt4, inst_cnt4;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cnn_inst_sequencer_if #(.INST_WIDTH(128), .ADDR_WIDTH(16)) bus ();
  cnn_inst_sequencer_if #(.INST_WIDTH(128), .ADDR_WIDTH(4))  bus4 ();

  cnn_inst_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .abort(abort),
    .timeout_limit(timeout_limit), .bus(bus), .ready(ready), .done(done),
    .status(status), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
  );

  cnn_inst_sequencer #(.ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .start_addr(start_addr4), .abort(1'b0),
    .timeout_limit(32'd0), .bus(bus4), .ready(ready4), .done(done4),
    .status(status4), .cycle_cnt(cycle_cnt4), .inst_cnt(inst_cnt4)
  );

  // ROM with two-cycle address-to-data latency
  logic [127:0] rom [16];
  logic [15:0]  a1 = '0, a2 = '0;
  always @(posedge clk) begin
    a1 <= bus.inst_addr;
    a2 <= a1;
  end
  assign bus.inst_q = rom[a2[3:0]];

  logic [127:0] rom4 [16];
  logic [3:0]   b1 = '0, b2 = '0;
  always @(posedge clk) begin
    b1 <= bus4.inst_addr;
    b2 <= b1;
  end
  assign bus4.inst_q = rom4[b2];
  assign bus4.parser_ready = 1'b1;

  // Parser: busy for 3 cycles after each issue; hang keeps it busy
  logic [3:0] busy = '0;
  logic       hang = 1'b0;
  int         en_cnt = 0;
  int         en_cnt4 = 0;
  always @(posedge clk) begin
    if (bus.parser_en) busy <= 4'd3;
    else if (busy != 0 && !hang) busy <= busy - 4'd1;
    if (bus.parser_en) en_cnt <= en_cnt + 1;
    if (bus4.parser_en) en_cnt4 <= en_cnt4 + 1;
  end
  assign bus.parser_ready = (busy == 0);

  localparam logic [127:0] INST_A  = {8'h10, 120'h0A0A};
  localparam logic [127:0] INST_B  = {8'h11, 120'h0B0B};
  localparam logic [127:0] INST_C  = {8'h12, 120'h0C0C};
  localparam logic [127:0] LOOP_N2 = {8'hFF, 88'h0, 16'd2, 16'd0};
  localparam logic [127:0] LOOP_N0 = {8'hFF, 88'h0, 16'd0, 16'd0};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_start(input logic [15:0] addr);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    start_addr = addr;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_en(input string tag, output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.parser_en) return;
    end
    chk(tag, 0, 1);
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (n < 500) begin
      @(posedge clk);
      #1;
      n++;
      if (done) return;
    end
    chk(tag, 0, 1);
  endtask

  initial begin
    int n;
    int base;
    for (int i = 0; i < 16; i++) begin
      rom[i] = '0;
      rom4[i] = '0;
    end
    rom[4] = INST_A;
    rom[5] = INST_B;
    rom[6] = INST_C;
    rom[0] = INST_A;
    rom[1] = LOOP_N2;
    rom4[15] = INST_C;

    #12;
    chk("rst_inst_addr", bus.inst_addr, 0);
    chk("rst_parser_inst", bus.parser_inst, 0);
    chk("rst_parser_en", bus.parser_en, 0);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_inst_cnt", inst_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // linear run
    base = en_cnt;
    run_start(16'd4);
    chk("lin_ready_low", ready, 0);
    chk("lin_inst_addr", bus.inst_addr, 4);
    wait_en("lin_en_seen", n);
    chk("lin_first_en_lat", n, 5);
    chk("lin_first_inst", bus.parser_inst, INST_A);
    wait_done("lin_done_seen", n);
    chk("lin_status", status, 0);
    chk("lin_inst_cnt", inst_cnt, 3);
    chk("lin_cycle_cnt", cycle_cnt, 37);
    chk("lin_en_pulses", en_cnt - base, 3);
    chk("lin_parser_inst", bus.parser_inst, INST_C);
    chk("lin_ready_done", ready, 1);
    @(posedge clk);
    #1;
    chk("lin_done_pulse", done, 0);
    chk("lin_status_hold", status, 0);

    // loop N=2
    base = en_cnt;
    run_start(16'd0);
    wait_done("loop2_done_seen", n);
    chk("loop2_status", status, 0);
    chk("loop2_inst_cnt", inst_cnt, 3);
    chk("loop2_en_pulses", en_cnt - base, 3);
    chk("loop2_cycle_cnt", cycle_cnt, 49);

    // loop N=0
    rom[1] = LOOP_N0;
    base = en_cnt;
    run_start(16'd0);
    wait_done("loop0_done_seen", n);
    chk("loop0_status", status, 0);
    chk("loop0_inst_cnt", inst_cnt, 1);
    chk("loop0_en_pulses", en_cnt - base, 1);
    chk("loop0_cycle_cnt", cycle_cnt, 19);

    // watchdog
    timeout_limit = 32'd20;
    hang = 1'b1;
    base = en_cnt;
    run_start(16'd4);
    wait_en("to_en_seen", n);
    wait_done("to_done_seen", n);
    chk("to_latency", n, 20);
    chk("to_status", status, 1);
    chk("to_en_pulses", en_cnt - base, 1);
    chk("to_inst_cnt", inst_cnt, 0);
    timeout_limit = 32'd0;
    @(negedge clk);
    hang = 1'b0;
    repeat (5) @(negedge clk);

    // abort during WAIT, with an ignored start first
    hang = 1'b1;
    run_start(16'd4);
    wait_en("ab_en_seen", n);
    repeat (6) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    start_addr = 16'd9;
    @(posedge clk);
    #1;
    chk("busy_start_addr", bus.inst_addr, 4);
    chk("busy_start_ready", ready, 0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("ab_done", done, 1);
    chk("ab_status", status, 2);
    chk("ab_ready", ready, 1);
    @(negedge clk);
    abort = 1'b0;
    hang = 1'b0;
    repeat (5) @(negedge clk);

    // clean restart after abort
    base = en_cnt;
    run_start(16'd4);
    chk("rs_cycle_cnt0", cycle_cnt, 0);
    chk("rs_inst_cnt0", inst_cnt, 0);
    chk("rs_status0", status, 0);
    wait_done("rs_done_seen", n);
    chk("rs_status", status, 0);
    chk("rs_inst_cnt", inst_cnt, 3);
    chk("rs_cycle_cnt", cycle_cnt, 37);
    chk("rs_en_pulses", en_cnt - base, 3);

    // pc overflow on 4-bit address instance
    base = en_cnt4;
    @(negedge clk);
    start4 = 1'b1;
    start_addr4 = 4'd15;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    n = 0;
    while (n < 100 && !done4) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ovf_done_seen", done4, 1);
    chk("ovf_status", status4, 3);
    chk("ovf_inst_cnt", inst_cnt4, 1);
    chk("ovf_en_pulses", en_cnt4 - base, 1);
    chk("ovf_pc_nowrap", bus4.inst_addr, 15);

    // async reset during SETTLE
    run_start(16'd4);
    wait_en("ar_en_seen", n);
    rst_n = 1'b0;
    #1;
    chk("ar_parser_en", bus.parser_en, 0);
    chk("ar_ready", ready, 1);
    chk("ar_cycle_cnt", cycle_cnt, 0);
    chk("ar_done", done, 0);
    chk("ar_inst_addr", bus.inst_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cnn_inst_sequencer.md
# cnn_inst_sequencer

Parametrised next-generation CNN instruction sequencer. It fetches instructions from the instruction ROM starting at a programmable address and issues compute instructions to the downstream instruction parser with an en/ready handshake. Beyond linear execution, it supports a single-level hardware LOOP opcode, a watchdog timeout, abort, and program-counter overflow detection, and it reports completion status and performance counters. It sits between the host/control register block and the parser, and the parser drives DDR.

## Interface
- DATA_WIDTH, 32, width of the counters and of timeout_limit
- INST_WIDTH, 128, instruction width
- ADDR_WIDTH, 16, instruction ROM address width
- ROM_LATENCY, 2, ROM read latency in cycles from address to q
- SETTLE_CYCLES, 5, cycles to wait after issue before parser_ready is trusted
- LOOP_OPCODE, 8'hFF, value of inst_q[INST_WIDTH-1 -: 8] that marks LOOP
- clk  in  1  sole clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  run request, sampled in IDLE only
- start_addr  in  ADDR_WIDTH  first instruction address
- abort  in  1  stop the run, level-sampled
- timeout_limit  in  DATA_WIDTH  per-instruction watchdog limit; 0 disables the watchdog
- inst_addr  out  ADDR_WIDTH  ROM address
- inst_q  in  INST_WIDTH  ROM data
- parser_inst  out  INST_WIDTH  latched instruction, stable from issue until the next issue
- parser_en  out  1  one-cycle issue pulse
- parser_ready  in  1  parser idle/complete
- ready  out  1  high iff the state is IDLE
- done  out  1  one-cycle pulse at the end of every run
- status  out  2  0 ok, 1 timeout, 2 abort, 3 pc overflow; valid with done and held until the next start
- cycle_cnt  out  DATA_WIDTH  cycles spent out of IDLE in the current or last run
- inst_cnt  out  DATA_WIDTH  compute instructions completed

## Operation
- States: IDLE, FETCH, DECODE, ISSUE, SETTLE, WAIT.
- IDLE
  - start=1 → pc←start_addr, cycle_cnt←0, inst_cnt←0, status←0, loop_active←0, go to FETCH.
  - start while busy is ignored.
- FETCH: inst_addr=pc; wait ROM_LATENCY+1 cycles, then go to DECODE.
- DECODE
  - inst_q==0 (NOP): end the run with status 0.
  - opcode==LOOP_OPCODE: target=inst_q[ADDR_WIDTH-1:0], N=inst_q[ADDR_WIDTH+15:ADDR_WIDTH].
    - !loop_active and N==0 → pc+1.
    - !loop_active and N>0 → loop_active←1, loop_cnt←N-1, pc←target.
    - loop_active and loop_cnt==0 → loop_active←0, pc+1.
    - loop_active and loop_cnt>0 → loop_cnt−1, pc←target.
    - Net effect: the body executes N+1 times.
    - Only one loop level is supported: an inner LOOP acts on the same counter.
    - Next state is FETCH.
  - Any other opcode: latch parser_inst. If parser_ready=1 go to ISSUE, otherwise stay in DECODE.
- ISSUE: parser_en=1 for exactly one cycle; wd_cnt←0; go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to WAIT.
- WAIT: parser_ready=1 → inst_cnt+1, pc+1, go to FETCH.
- Watchdog: wd_cnt increments each cycle in SETTLE and WAIT. When timeout_limit≠0 and wd_cnt≥timeout_limit, end the run with status 1.
- pc overflow: pc+1 when pc=2^ADDR_WIDTH−1 ends the run with status 3. pc does not wrap.
- abort=1 in any non-IDLE state ends the run with status 2 on the next edge.
  - Abort has priority over every other transition.
  - An in-flight parser operation is not cancelled.
- Ending a run: go to IDLE, pulse done, force parser_en=0.
- cycle_cnt increments every cycle the state is not IDLE, saturates at all-ones, and holds in IDLE.

## Timing
- Reset values: inst_addr 0, parser_inst 0, parser_en 0, ready 1, done 0, status 0, cycle_cnt 0, inst_cnt 0. All internal state resets to IDLE, pc 0, loop_active 0.
- start accepted at edge t: ready=0 and inst_addr=start_addr after t.
- First parser_en at t+ROM_LATENCY+3, assuming parser_ready=1.
- Minimum per compute instruction: FETCH ROM_LATENCY+1, DECODE 1, ISSUE 1, SETTLE SETTLE_CYCLES, WAIT ≥1. With defaults that is 11 cycles.
- LOOP costs ROM_LATENCY+2 cycles and issues nothing.
- done is asserted in the cycle ready returns high.
- start in the same cycle as done is not accepted: start is sampled in IDLE only.
- rst_n asserted mid-run: all outputs return immediately to reset values, with no done pulse.

## Test plan
- Linear run: start_addr=4, ROM[4..6]=three compute instructions, ROM[7]=0, parser_ready=1 after 3 cycles → three parser_en pulses, done with status 0, inst_cnt=3, first parser_en exactly 5 cycles after start.
- Loop: ROM[0]=A, ROM[1]=LOOP{target 0, N=2}, ROM[2]=0 → A issued 3 times, then done with status 0, inst_cnt=3. Variant with N=0 → A issued once.
- Timeout: timeout_limit=20, parser_ready held 0 after issue → done with status 1 at 20 cycles after ISSUE, parser_en pulsed once.
- Abort: abort=1 during WAIT → done on the next cycle with status 2, ready=1. A subsequent start restarts cleanly with counters cleared.
- Overflow: ADDR_WIDTH=4, start_addr=15, ROM[15]=compute instruction → issued once, then done with status 3.
- Async reset asserted during SETTLE → parser_en=0, ready=1, cycle_cnt=0 with no clock edge. start ignored while busy (second start during WAIT → no effect).
